// File: rtl/stack_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : stack_sequencer
// Description : Command sequencer in front of the 64-entry register stack.
//               It accepts stack-level commands over a valid/ready handshake
//               and turns each one into one or two primitive stack ops
//               (stackOP and w). It reads back the top two entries (a, b) to
//               build composite ops, and tracks depth to reject commands that
//               would overflow or underflow the stack.
//
//               Ports:
//                 CLK        system clock, state updates on posedge
//                 reset      asynchronous, active-low
//                 cmd_valid  command present
//                 cmd_ready  sequencer can accept a command
//                 cmd        4-bit command code
//                 din        immediate / ALU result for PUSH and POPREP
//                 a, b       stack top and second entry, from the stack
//                 stackOP    primitive op to the stack (0 none, 1 push,
//                            2 pop-and-replace, 3 pop, 4 pop2, 5 swap)
//                 w          write data for push and pop-and-replace
//                 depth      current entry count, 0..DEPTH
//                 busy       second step of a two-step command pending
//                 ovf, unf   one-cycle rejection pulses
//                 err        sticky error flag, cleared only by reset
// Revision    : 1.0 - initial release
// ============================================================================
module stack_sequencer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd,
  input  logic [WIDTH-1:0]       din,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  output logic [2:0]             stackOP,
  output logic [WIDTH-1:0]       w,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   busy,
  output logic                   ovf,
  output logic                   unf,
  output logic                   err
);

  localparam int c_DW = $clog2(DEPTH) + 1;

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_STEP2 = 1'b1;

  localparam logic [2:0] c_OP_NONE   = 3'd0;
  localparam logic [2:0] c_OP_PUSH   = 3'd1;
  localparam logic [2:0] c_OP_POPREP = 3'd2;
  localparam logic [2:0] c_OP_POP    = 3'd3;
  localparam logic [2:0] c_OP_POP2   = 3'd4;
  localparam logic [2:0] c_OP_SWAP   = 3'd5;

  localparam logic [3:0] c_CMD_NOP    = 4'd0;
  localparam logic [3:0] c_CMD_PUSH   = 4'd1;
  localparam logic [3:0] c_CMD_POP    = 4'd2;
  localparam logic [3:0] c_CMD_DROP2  = 4'd3;
  localparam logic [3:0] c_CMD_SWAP   = 4'd4;
  localparam logic [3:0] c_CMD_DUP    = 4'd5;
  localparam logic [3:0] c_CMD_OVER   = 4'd6;
  localparam logic [3:0] c_CMD_NIP    = 4'd7;
  localparam logic [3:0] c_CMD_POPREP = 4'd8;
  localparam logic [3:0] c_CMD_TUCK   = 4'd9;
  localparam logic [3:0] c_CMD_2DUP   = 4'd10;

  // Write-data source select
  localparam logic [1:0] c_WSEL_DIN = 2'd0;
  localparam logic [1:0] c_WSEL_A   = 2'd1;
  localparam logic [1:0] c_WSEL_B   = 2'd2;

  logic [0:0]       r_state;
  logic             r_live;     // low from reset until the first posedge after release
  logic [2:0]       r_stackop;
  logic [WIDTH-1:0] r_w;
  logic [c_DW-1:0]  r_depth;
  logic             r_ovf;
  logic             r_unf;
  logic             r_err;

  logic [2:0]       w_op;
  logic [1:0]       w_need;
  logic [1:0]       w_inc;
  logic [1:0]       w_dec;
  logic [1:0]       w_wsel;
  logic             w_two;
  logic             w_rsvd;
  logic [WIDTH-1:0] w_wdata;
  logic [c_DW:0]    w_sum;
  logic             w_unf;
  logic             w_ovf;
  logic             w_accept;

  // Command decode: step-1 op, operands needed, depth increase/decrease.
  // For two-step commands the full depth change is carried in w_inc.
  always_comb begin
    w_op   = c_OP_NONE;
    w_need = 2'd0;
    w_inc  = 2'd0;
    w_dec  = 2'd0;
    w_wsel = c_WSEL_DIN;
    w_two  = 1'b0;
    w_rsvd = 1'b0;
    case (cmd)
      c_CMD_NOP:    ;
      c_CMD_PUSH:   begin w_op = c_OP_PUSH;   w_inc = 2'd1; end
      c_CMD_POP:    begin w_op = c_OP_POP;    w_need = 2'd1; w_dec = 2'd1; end
      c_CMD_DROP2:  begin w_op = c_OP_POP2;   w_need = 2'd2; w_dec = 2'd2; end
      c_CMD_SWAP:   begin w_op = c_OP_SWAP;   w_need = 2'd2; end
      c_CMD_DUP:    begin w_op = c_OP_PUSH;   w_need = 2'd1; w_inc = 2'd1; w_wsel = c_WSEL_A; end
      c_CMD_OVER:   begin w_op = c_OP_PUSH;   w_need = 2'd2; w_inc = 2'd1; w_wsel = c_WSEL_B; end
      c_CMD_NIP:    begin w_op = c_OP_POPREP; w_need = 2'd2; w_dec = 2'd1; w_wsel = c_WSEL_A; end
      c_CMD_POPREP: begin w_op = c_OP_POPREP; w_need = 2'd2; w_dec = 2'd1; end
      c_CMD_TUCK:   begin w_op = c_OP_SWAP;   w_need = 2'd2; w_inc = 2'd1; w_two = 1'b1; end
      c_CMD_2DUP:   begin w_op = c_OP_PUSH;   w_need = 2'd2; w_inc = 2'd2; w_two = 1'b1;
                          w_wsel = c_WSEL_B; end
      default:      w_rsvd = 1'b1;
    endcase
  end

  always_comb begin
    w_wdata = din;
    case (w_wsel)
      c_WSEL_A: w_wdata = a;
      c_WSEL_B: w_wdata = b;
      default:  w_wdata = din;
    endcase
  end

  // One extra bit so depth + increase cannot wrap before the compare.
  assign w_sum    = {1'b0, r_depth} + (c_DW+1)'(w_inc);
  assign w_unf    = r_depth < c_DW'(w_need);
  assign w_ovf    = w_sum > (c_DW+1)'(DEPTH);
  assign w_accept = cmd_valid && cmd_ready;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state   <= c_IDLE;
      r_live    <= 1'b0;
      r_stackop <= c_OP_NONE;
      r_w       <= '0;
      r_depth   <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_live    <= 1'b1;
      r_stackop <= c_OP_NONE;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            if (w_rsvd) begin
              r_err <= 1'b1;
            end else if (w_unf) begin
              // Underflow takes priority over overflow
              r_unf <= 1'b1;
              r_err <= 1'b1;
            end else if (w_ovf) begin
              r_ovf <= 1'b1;
              r_err <= 1'b1;
            end else begin
              r_stackop <= w_op;
              if (w_op == c_OP_PUSH || w_op == c_OP_POPREP) begin
                r_w <= w_wdata;
              end
              r_depth <= r_depth + c_DW'(w_inc) - c_DW'(w_dec);
              if (w_two) begin
                r_state <= c_STEP2;
              end
            end
          end
        end
        c_STEP2: begin
          // Both two-step commands finish with a push of the (already
          // updated) second entry.
          r_stackop <= c_OP_PUSH;
          r_w       <= b;
          r_state   <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_live && (r_state == c_IDLE);
  assign busy      = (r_state == c_STEP2);
  assign stackOP   = r_stackop;
  assign w         = r_w;
  assign depth     = r_depth;
  assign ovf       = r_ovf;
  assign unf       = r_unf;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_stack_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_sequencer
// Description : Directed self-checking bench for stack_sequencer. Contains a
//               behavioural model of the negedge-updated register stack that
//               feeds a/b back to the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_sequencer;

  localparam int DEPTH = 64;
  localparam int WIDTH = 16;

  logic             CLK = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       stackOP;
  logic [WIDTH-1:0] w;
  logic [6:0]       depth;
  logic             busy;
  logic             ovf;
  logic             unf;
  logic             err;

  int n_vec = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] st [0:DEPTH-1];   // st[0] is the top of stack

  stack_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .din(din), .a(a), .b(b), .stackOP(stackOP), .w(w),
    .depth(depth), .busy(busy), .ovf(ovf), .unf(unf), .err(err)
  );

  always #5 CLK = ~CLK;

  assign a = st[0];
  assign b = st[1];

  // Stack model: applies the issued op on the falling edge.
  always @(negedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) st[i] <= '0;
    end else begin
      case (stackOP)
        3'd1: begin
          for (int i = 1; i < DEPTH; i++) st[i] <= st[i-1];
          st[0] <= w;
        end
        3'd2: begin
          for (int i = 1; i < DEPTH-1; i++) st[i] <= st[i+1];
          st[0] <= w;
        end
        3'd3: for (int i = 0; i < DEPTH-1; i++) st[i] <= st[i+1];
        3'd4: for (int i = 0; i < DEPTH-2; i++) st[i] <= st[i+2];
        3'd5: begin st[0] <= st[1]; st[1] <= st[0]; end
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Present one command for one posedge, then sample 1 time unit later.
  task automatic step(input logic [3:0] c, input logic [WIDTH-1:0] d);
    cmd_valid = 1'b1;
    cmd       = c;
    din       = d;
    @(posedge CLK);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic tick();
    cmd_valid = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd       = 4'd0;
    din       = '0;
    #2;
    chk("rst_stackop", 32'(stackOP), 0);
    chk("rst_w", 32'(w), 0);
    chk("rst_depth", 32'(depth), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_unf", 32'(unf), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ready", 32'(cmd_ready), 0);
    #20 reset = 1'b1;
    @(posedge CLK);
    #1;
    chk("ready_after_rel", 32'(cmd_ready), 1);

    // Back-to-back pushes
    step(4'd1, 16'h0011);
    chk("push1_op", 32'(stackOP), 1);
    chk("push1_w", 32'(w), 32'h11);
    chk("push1_depth", 32'(depth), 1);
    step(4'd1, 16'h0022);
    chk("push2_op", 32'(stackOP), 1);
    chk("push2_w", 32'(w), 32'h22);
    chk("push2_depth", 32'(depth), 2);
    tick();
    chk("idle_op", 32'(stackOP), 0);
    chk("idle_w_hold", 32'(w), 32'h22);
    chk("stk_a", 32'(a), 32'h22);
    chk("stk_b", 32'(b), 32'h11);

    // TUCK
    step(4'd9, 16'h0000);
    chk("tuck1_op", 32'(stackOP), 5);
    chk("tuck1_ready", 32'(cmd_ready), 0);
    chk("tuck1_busy", 32'(busy), 1);
    chk("tuck1_depth", 32'(depth), 3);
    tick();
    chk("tuck2_op", 32'(stackOP), 1);
    chk("tuck2_w", 32'(w), 32'h22);
    chk("tuck2_ready", 32'(cmd_ready), 1);
    chk("tuck2_busy", 32'(busy), 0);
    tick();
    chk("tuck_st0", 32'(st[0]), 32'h22);
    chk("tuck_st1", 32'(st[1]), 32'h11);
    chk("tuck_st2", 32'(st[2]), 32'h22);

    // Back to depth 2 (stack 11,22), then 2DUP and DROP2
    step(4'd2, 16'h0000);
    chk("pop_op", 32'(stackOP), 3);
    chk("pop_depth", 32'(depth), 2);
    step(4'd10, 16'h0000);
    chk("2dup1_op", 32'(stackOP), 1);
    chk("2dup1_w", 32'(w), 32'h22);
    chk("2dup1_depth", 32'(depth), 4);
    tick();
    chk("2dup2_op", 32'(stackOP), 1);
    chk("2dup2_w", 32'(w), 32'h11);
    tick();
    chk("2dup_st0", 32'(st[0]), 32'h11);
    chk("2dup_st1", 32'(st[1]), 32'h22);
    chk("2dup_st2", 32'(st[2]), 32'h11);
    chk("2dup_st3", 32'(st[3]), 32'h22);
    step(4'd3, 16'h0000);
    chk("drop2_op", 32'(stackOP), 4);
    chk("drop2_depth", 32'(depth), 2);

    // Remaining single-step commands, back-to-back (stack 11,22)
    step(4'd6, 16'h0000);
    chk("over_op", 32'(stackOP), 1);
    chk("over_w", 32'(w), 32'h22);
    chk("over_depth", 32'(depth), 3);
    step(4'd7, 16'h0000);
    chk("nip_op", 32'(stackOP), 2);
    chk("nip_w", 32'(w), 32'h22);
    chk("nip_depth", 32'(depth), 2);
    step(4'd8, 16'h0055);
    chk("poprep_op", 32'(stackOP), 2);
    chk("poprep_w", 32'(w), 32'h55);
    chk("poprep_depth", 32'(depth), 1);
    step(4'd5, 16'h0000);
    chk("dup_op", 32'(stackOP), 1);
    chk("dup_w", 32'(w), 32'h55);
    chk("dup_depth", 32'(depth), 2);
    step(4'd4, 16'h0000);
    chk("swap_op", 32'(stackOP), 5);
    chk("swap_depth", 32'(depth), 2);
    step(4'd0, 16'h0000);
    chk("nop_op", 32'(stackOP), 0);
    chk("nop_depth", 32'(depth), 2);
    chk("no_err_yet", 32'(err), 0);

    // Underflow from a fresh reset
    #3 reset = 1'b0;
    @(posedge CLK);
    #3 reset = 1'b1;
    @(posedge CLK);
    #1;
    chk("rst2_depth", 32'(depth), 0);
    step(4'd2, 16'h0000);
    chk("unf_op", 32'(stackOP), 0);
    chk("unf_pulse", 32'(unf), 1);
    chk("unf_noovf", 32'(ovf), 0);
    chk("unf_err", 32'(err), 1);
    chk("unf_depth", 32'(depth), 0);
    step(4'd1, 16'h0033);
    chk("unf_clear", 32'(unf), 0);
    chk("after_unf_op", 32'(stackOP), 1);
    chk("after_unf_w", 32'(w), 32'h33);
    chk("after_unf_depth", 32'(depth), 1);
    chk("err_sticky", 32'(err), 1);

    // Fill to capacity, then overflow
    for (int i = 1; i < 64; i++) step(4'd1, 16'(i));
    chk("full_depth", 32'(depth), 64);
    step(4'd1, 16'hBEEF);
    chk("ovf_pulse", 32'(ovf), 1);
    chk("ovf_nounf", 32'(unf), 0);
    chk("ovf_op", 32'(stackOP), 0);
    chk("ovf_depth", 32'(depth), 64);
    chk("ovf_w_hold", 32'(w), 32'h3F);
    tick();
    chk("ovf_clear", 32'(ovf), 0);
    step(4'd2, 16'h0000);
    chk("pop63_op", 32'(stackOP), 3);
    chk("pop63_depth", 32'(depth), 63);
    step(4'd10, 16'h0000);
    chk("2dup_ovf", 32'(ovf), 1);
    chk("2dup_ovf_op", 32'(stackOP), 0);
    chk("2dup_ovf_depth", 32'(depth), 63);
    chk("2dup_ovf_busy", 32'(busy), 0);
    chk("2dup_ovf_ready", 32'(cmd_ready), 1);

    // Async reset during STEP2
    step(4'd9, 16'h0000);
    chk("tuck63_busy", 32'(busy), 1);
    chk("tuck63_depth", 32'(depth), 64);
    #3 reset = 1'b0;
    #1;
    chk("arst_op", 32'(stackOP), 0);
    chk("arst_w", 32'(w), 0);
    chk("arst_depth", 32'(depth), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ready", 32'(cmd_ready), 0);
    chk("arst_err", 32'(err), 0);
    chk("arst_ovf", 32'(ovf), 0);
    @(posedge CLK);
    #3 reset = 1'b1;
    @(posedge CLK);
    #1;
    chk("arel_ready", 32'(cmd_ready), 1);
    chk("arel_op", 32'(stackOP), 0);
    step(4'd12, 16'h0000);
    chk("rsvd_err", 32'(err), 1);
    chk("rsvd_ovf", 32'(ovf), 0);
    chk("rsvd_unf", 32'(unf), 0);
    chk("rsvd_op", 32'(stackOP), 0);
    chk("rsvd_depth", 32'(depth), 0);
    chk("rsvd_ready", 32'(cmd_ready), 1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stack_sequencer.md
# stack_sequencer

Command sequencer that sits directly upstream of the 64-entry register stack in processor-2v. It accepts stack-level commands from the decode/ALU stage over a valid/ready handshake and drives the stack's stackOP and w inputs. It reads the stack's top two entries (a, b) back to build composite operations, and tracks stack depth to block overflow and underflow. All outputs are registered on posedge CLK, so the stack, which updates on negedge CLK, applies each issued op in the same cycle.

## Interface
- DEPTH, 64: stack capacity; must match the stack's size.
- WIDTH, 16: data width.
- CLK  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; 0 resets the block immediately. The top level drives the stack's reset from the inverse of this signal.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high when state is IDLE and reset is released.
- cmd  in  4  command code (see Operation).
- din  in  WIDTH  immediate or ALU result used by PUSH and POPREP.
- a  in  WIDTH  stack top, from the stack.
- b  in  WIDTH  stack second entry, from the stack.
- stackOP  out  3  primitive op: 0 none, 1 push, 2 pop-and-replace, 3 pop, 4 pop 2, 5 swap.
- w  out  WIDTH  write data for push and pop-and-replace.
- depth  out  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
- busy  out  1  high while the second step of a two-step command is pending.
- ovf  out  1  one-cycle pulse: command rejected because the stack is full.
- unf  out  1  one-cycle pulse: command rejected because there are too few operands.
- err  out  1  sticky; set by any ovf, unf or reserved code; cleared only by reset.

## Operation
- A command is accepted on a posedge where cmd_valid and cmd_ready are both high.
- Each entry below gives code, name, stackOP and w, operands needed, and depth change:
  - 0 NOP: 0; needs 0; change 0.
  - 1 PUSH: 1, w=din; needs 0; +1.
  - 2 POP: 3; needs 1; −1.
  - 3 DROP2: 4; needs 2; −2.
  - 4 SWAP: 5; needs 2; 0.
  - 5 DUP: 1, w=a; needs 1; +1.
  - 6 OVER: 1, w=b; needs 2; +1.
  - 7 NIP: 2, w=a; needs 2; −1.
  - 8 POPREP: 2, w=din; needs 2; −1.
  - 9 TUCK: step 1 is 5, step 2 is 1 with w=b; needs 2; +1.
  - 10 2DUP: step 1 is 1 with w=b, step 2 is 1 with w=b; needs 2; +2.
- Codes 11–15 are reserved: accepted, stackOP=0, depth unchanged, err set, no ovf or unf pulse.
- Checks at acceptance:
  - Underflow: depth < operands needed.
  - Overflow: depth + change > DEPTH.
  - If both apply, underflow wins: unf pulses, ovf does not.
  - A rejected command still completes the handshake. It issues stackOP=0, leaves depth unchanged and stays in IDLE.
- FSM states:
  - IDLE: on accepting a legal two-step command, issue step 1 and go to STEP2. All other accepts stay in IDLE.
  - STEP2: issue step 2, sampling a and b as already updated by step 1, then return to IDLE. cmd_ready=0 and busy=1.
- depth is updated once, by the full change, in the acceptance cycle.
- stackOP returns to 0 on every posedge with no issue. w holds its last value.

## Timing
- Reset (reset=0) forces, asynchronously: stackOP=0, w=0, depth=0, state IDLE, busy=0, ovf=0, unf=0, err=0, cmd_ready=0.
- cmd_ready rises in the first cycle after reset deasserts.
- Reset asserted during STEP2 aborts step 2. The stack is reset alongside the block.
- Latency: stackOP and w are valid from the acceptance posedge until the next posedge. The stack applies them at the intervening negedge.
- Single-step commands sustain one per cycle. A command accepted at posedge k+1 sees a and b reflecting the op issued at k.
- Two-step commands occupy two cycles. cmd_ready is low for exactly one cycle.
- ovf and unf are high for exactly the one cycle following the rejecting posedge.

## Test plan
- Reset, then PUSH 0x0011 followed by PUSH 0x0022 back-to-back -> stackOP 1,1 on consecutive cycles; w=0x0011 then 0x0022; depth=2; a=0x0022, b=0x0011.
- With a=0x0022 and b=0x0011 (depth 2), TUCK -> stackOP 5 then stackOP 1 with w=0x0022; cmd_ready low for one cycle; stack top-first reads 0x0022, 0x0011, 0x0022; depth=3.
- With depth 2, 2DUP -> stackOP 1,1 with w=b for each step; stack reads a, b, a, b; depth=4. Then DROP2 -> stackOP 4; depth=2.
- Underflow: from reset, POP -> stackOP 0; unf pulses one cycle; err=1 and stays 1; depth=0. A following PUSH executes normally.
- Overflow: 64 PUSHes, then PUSH 0xBEEF -> ovf pulse, stackOP 0, depth stays 64. From depth 63, 2DUP -> ovf, depth stays 63.
- Async reset asserted mid-cycle during STEP2 -> all outputs drop to their reset values immediately, with no posedge required; cmd_ready=1 one cycle after release; cmd=12 afterwards -> err=1, with no ovf or unf pulse.
